// File: rtl/shift_taps_param.sv
// Parametrised tapped delay line with fill tracking and per-tap valid flags.
// Optional registered tap sum enabled by defining SHIFT_TAPS_SUM_EN.
module shift_taps_param #(
  parameter int WIDTH       = 8,
  parameter int DEPTH       = 64,
  parameter int NUM_TAPS    = 3,
  parameter int TAP_SPACING = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      shift,
  input  logic                      clear,
  input  logic [WIDTH-1:0]          sr_in,
  output logic [NUM_TAPS*WIDTH-1:0] sr_taps,
  output logic [NUM_TAPS-1:0]       tap_valid,
  output logic [WIDTH-1:0]          sr_out,
  output logic                      out_valid,
  output logic [$clog2(DEPTH+1)-1:0] fill_level,
  output logic                      full
`ifdef SHIFT_TAPS_SUM_EN
  ,
  output logic [WIDTH+$clog2(NUM_TAPS+2)-1:0] tap_sum,
  output logic                      sum_valid
`endif
);

  localparam int FW = $clog2(DEPTH+1);

  if (NUM_TAPS*TAP_SPACING >= DEPTH || DEPTH < 2 || NUM_TAPS < 1) begin : g_bad
    $error("shift_taps_param: illegal DEPTH/NUM_TAPS/TAP_SPACING");
  end

  logic [WIDTH-1:0] stage [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int j = 0; j < DEPTH; j++) stage[j] <= '0;
    end else if (clear) begin
      for (int j = 0; j < DEPTH; j++) stage[j] <= '0;
    end else if (shift) begin
      stage[0] <= sr_in;
      for (int j = 1; j < DEPTH; j++) stage[j] <= stage[j-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fill_level <= '0;
    end else if (clear) begin
      fill_level <= '0;
    end else if (shift && fill_level != FW'(DEPTH)) begin
      fill_level <= fill_level + 1'b1;
    end
  end

  assign full      = (fill_level == FW'(DEPTH));
  assign out_valid = full;
  assign sr_out    = stage[DEPTH-1];

  for (genvar k = 0; k < NUM_TAPS; k++) begin : g_tap
    assign sr_taps[k*WIDTH +: WIDTH] = stage[(k+1)*TAP_SPACING-1];
    assign tap_valid[k] = (fill_level >= FW'((k+1)*TAP_SPACING));
  end

`ifdef SHIFT_TAPS_SUM_EN
  localparam int SW = WIDTH + $clog2(NUM_TAPS+2);

  logic [SW-1:0] sum_next;

  always_comb begin
    sum_next = '0;
    for (int k = 1; k <= NUM_TAPS; k++)
      sum_next = sum_next + SW'(stage[k*TAP_SPACING-1]);
    sum_next = sum_next + SW'(stage[DEPTH-1]);
  end

  // Sum trails the stage data by one edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tap_sum   <= '0;
      sum_valid <= 1'b0;
    end else if (clear) begin
      tap_sum   <= '0;
      sum_valid <= 1'b0;
    end else begin
      tap_sum   <= sum_next;
      sum_valid <= full;
    end
  end
`endif

endmodule

// File: tb/tb_shift_taps_param.sv
// Randomised self-checking bench for shift_taps_param against a
// sample-history model; directed scenarios pin the model with literals.
module tb_shift_taps_param;

  localparam int W  = 8;
  localparam int D  = 64;
  localparam int NT = 3;
  localparam int TS = 16;

  logic          clk = 0;
  logic          rst_n = 0;
  logic          shift = 0;
  logic          clear = 0;
  logic [W-1:0]  sr_in = 0;
  logic [NT*W-1:0] sr_taps;
  logic [NT-1:0] tap_valid;
  logic [W-1:0]  sr_out;
  logic          out_valid;
  logic [6:0]    fill_level;
  logic          full;
`ifdef SHIFT_TAPS_SUM_EN
  logic [10:0]   tap_sum;
  logic          sum_valid;
`endif

  shift_taps_param #(
    .WIDTH(W), .DEPTH(D), .NUM_TAPS(NT), .TAP_SPACING(TS)
  ) dut (
    .clk(clk), .rst_n(rst_n), .shift(shift), .clear(clear),
    .sr_in(sr_in), .sr_taps(sr_taps), .tap_valid(tap_valid),
    .sr_out(sr_out), .out_valid(out_valid),
    .fill_level(fill_level), .full(full)
`ifdef SHIFT_TAPS_SUM_EN
    , .tap_sum(tap_sum), .sum_valid(sum_valid)
`endif
  );

  always #5 clk = ~clk;

  int n_tot  = 0;
  int n_pass = 0;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_tot++;
    if (act !== exp)
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    else
      n_pass++;
  endtask

  // Model: history of accepted samples, newest first, capped at D.
  int hist[$];
  int msum = 0;
  bit msv = 0;

  function automatic int mstage(int j);
    return (j < hist.size()) ? hist[j] : 0;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist.delete();
      msum = 0;
      msv  = 0;
    end else begin
      if (clear) begin
        msum = 0;
        msv  = 0;
      end else begin
        msum = mstage(D-1);
        for (int k = 1; k <= NT; k++) msum += mstage(k*TS-1);
        msv = (hist.size() == D);
      end
      if (clear) hist.delete();
      else if (shift) begin
        hist.push_front(int'(sr_in));
        if (hist.size() > D) void'(hist.pop_back());
      end
    end
  end

  always @(negedge clk) begin
    int n;
    n = hist.size();
    chk("fill_level", 64'(fill_level), 64'(n));
    chk("full", 64'(full), 64'(n == D));
    chk("out_valid", 64'(out_valid), 64'(n == D));
    chk("sr_out", 64'(sr_out), 64'(mstage(D-1)));
    for (int k = 1; k <= NT; k++) begin
      chk("tap", 64'(sr_taps[(k-1)*W +: W]), 64'(mstage(k*TS-1)));
      chk("tap_valid", 64'(tap_valid[k-1]), 64'(n >= k*TS));
    end
`ifdef SHIFT_TAPS_SUM_EN
    chk("tap_sum", 64'(tap_sum), 64'(msum));
    chk("sum_valid", 64'(sum_valid), 64'(msv));
`endif
  end

  task automatic step(bit sh, bit cl, logic [W-1:0] din);
    @(negedge clk);
    shift = sh;
    clear = cl;
    sr_in = din;
    @(posedge clk);
    #1;
    shift = 0;
    clear = 0;
  endtask

  logic [NT*W-1:0] snap_taps;
  logic [W-1:0]    snap_out;

  initial begin
    rst_n = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1;
    @(posedge clk);
    #1;
    chk("rst_taps", 64'(sr_taps), 64'(0));
    chk("rst_out", 64'(sr_out), 64'(0));
    chk("rst_fill", 64'(fill_level), 64'(0));
    chk("rst_tv", 64'(tap_valid), 64'(0));
    chk("rst_full", 64'({out_valid, full}), 64'(0));

    for (int i = 1; i <= 64; i++) begin
      step(1, 0, W'(i));
      if (i == 16) begin
        chk("fill16_tv", 64'(tap_valid), 64'(3'b001));
        chk("fill16_tap1", 64'(sr_taps[W-1:0]), 64'(1));
      end
    end
    chk("fill_tap1", 64'(sr_taps[W-1:0]), 64'(49));
    chk("fill_tap2", 64'(sr_taps[2*W-1:W]), 64'(33));
    chk("fill_tap3", 64'(sr_taps[3*W-1:2*W]), 64'(17));
    chk("fill_out", 64'(sr_out), 64'(1));
    chk("fill_lvl", 64'(fill_level), 64'(64));
    chk("fill_full", 64'(full), 64'(1));
    chk("fill_tv", 64'(tap_valid), 64'(3'b111));

    snap_taps = sr_taps;
    snap_out  = sr_out;
    for (int i = 0; i < 10; i++) begin
      step(0, 0, (i % 2) ? 8'hFF : 8'h00);
`ifdef SHIFT_TAPS_SUM_EN
      if (i == 0) begin
        chk("sum100", 64'(tap_sum), 64'(100));
        chk("sum_valid", 64'(sum_valid), 64'(1));
      end
`endif
    end
    chk("hold_taps", 64'(sr_taps), 64'(snap_taps));
    chk("hold_out", 64'(sr_out), 64'(snap_out));
    chk("hold_lvl", 64'(fill_level), 64'(64));

    for (int i = 65; i <= 70; i++) step(1, 0, W'(i));
    chk("sat_lvl", 64'(fill_level), 64'(64));
    chk("sat_out", 64'(sr_out), 64'(7));
    chk("sat_tap1", 64'(sr_taps[W-1:0]), 64'(55));

    step(0, 1, 0);
    for (int i = 0; i < 20; i++) step(1, 0, W'($urandom));
    chk("pre_clr_lvl", 64'(fill_level), 64'(20));
    step(1, 1, 8'hAA);
    chk("clr_lvl", 64'(fill_level), 64'(0));
    chk("clr_taps", 64'(sr_taps), 64'(0));
    chk("clr_out", 64'(sr_out), 64'(0));
    step(1, 0, 8'h11);
    chk("clr_post_lvl", 64'(fill_level), 64'(1));
    chk("clr_post_tv", 64'(tap_valid), 64'(0));

    step(0, 1, 0);
    for (int i = 0; i < 30; i++) step(1, 0, W'($urandom_range(1, 255)));
    chk("pre_rst_lvl", 64'(fill_level), 64'(30));
    @(negedge clk);
    #2;
    rst_n = 0;
    #1;
    chk("arst_lvl", 64'(fill_level), 64'(0));
    chk("arst_taps", 64'(sr_taps), 64'(0));
    chk("arst_tv", 64'(tap_valid), 64'(0));
    @(negedge clk);
    rst_n = 1;
    step(1, 0, 8'h5A);
    chk("arst_post_lvl", 64'(fill_level), 64'(1));

    for (int i = 0; i < 1500; i++) begin
      int r;
      r = $urandom_range(0, 99);
      step(r < 70, r >= 97, W'($urandom));
    end

    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
